// File: rtl/regfile_pkg.sv
// Shared defaults for the pipelined register file: geometry and the
// index of the hardwired-zero register (XZR).
package regfile_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NRD   = 2;
  localparam int DEF_AW    = $clog2(DEF_DEPTH);
  localparam int XZR_IDX   = DEF_DEPTH - 1;

endpackage

// File: rtl/regfile_pipe_mux_n_1.sv
// Pure N:1 selector over a packed bus; one instance serves each read port.
module mux_n_1 #(
  parameter  int WIDTH = 64,
  parameter  int N     = 32,
  localparam int SW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*WIDTH-1:0] data_i,
  input  logic [SW-1:0]      sel_i,
  output logic [WIDTH-1:0]   data_o
);

  always_comb begin
    data_o = data_i[sel_i*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/regfile_pipe.sv
// Multi-read-port register file with one-cycle registered reads,
// write-through bypass and an optional hardwired-zero top register.
module regfile_pipe
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int NRD      = DEF_NRD,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_valid
);

  logic [DEPTH*WIDTH-1:0] regs_q;
  logic [DEPTH-1:0]       wrSel;
  logic [WIDTH-1:0]       muxOut   [NRD];
  logic [WIDTH-1:0]       rdData_d [NRD];
  logic [WIDTH-1:0]       rdData_q [NRD];
  logic [NRD-1:0]         rdValid_q;

  function automatic logic isXzr(input logic [AW-1:0] addr);
    return (ZERO_REG != 0) && (addr == AW'(DEPTH - 1));
  endfunction

  // The zero register never gets a write enable, so it stays at its reset value.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wrSel[i] = wr_en && (wr_addr == AW'(i)) && !isXzr(AW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wrSel[i]) regs_q[i*WIDTH +: WIDTH] <= wr_data;
      end
    end
  end

  genvar p;
  generate
    for (p = 0; p < NRD; p++) begin : g_rd
      mux_n_1 #(
        .WIDTH (WIDTH),
        .N     (DEPTH)
      ) u_mux (
        .data_i (regs_q),
        .sel_i  (rd_addr[p*AW +: AW]),
        .data_o (muxOut[p])
      );
    end
  endgenerate

  // Zero-register override takes priority over the same-cycle write bypass.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rdData_d[i] = muxOut[i];
      if (wr_en && (wr_addr == rd_addr[i*AW +: AW])) rdData_d[i] = wr_data;
      if (isXzr(rd_addr[i*AW +: AW])) rdData_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdValid_q <= '0;
      for (int i = 0; i < NRD; i++) rdData_q[i] <= '0;
    end else begin
      rdValid_q <= rd_en;
      for (int i = 0; i < NRD; i++) begin
        if (rd_en[i]) rdData_q[i] <= rdData_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) rd_data[i*WIDTH +: WIDTH] = rdData_q[i];
  end

  assign rd_valid = rdValid_q;

endmodule

// File: tb/tb_regfile_pipe.sv
// Directed bench for regfile_pipe: a vector table plus hand-written sweep,
// zero-register and reset sequences; a ZERO_REG=0 instance covers plain storage.
module tb_regfile_pipe;
  import regfile_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          wrEn;
  logic [4:0]    wrAddr;
  logic [63:0]   wrData;
  logic [1:0]    rdEn;
  logic [9:0]    rdAddr;
  logic [127:0]  rdDataA, rdDataB;
  logic [1:0]    rdValidA, rdValidB;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0123_4567;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [1:0]  expValid;
    logic [63:0] exp0;
    logic [63:0] exp1;
  } vec_t;

  vec_t vecs [14];

  regfile_pipe #(.WIDTH(64), .DEPTH(32), .NRD(2), .ZERO_REG(1)) dutA (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wrEn),
    .wr_addr  (wrAddr),
    .wr_data  (wrData),
    .rd_en    (rdEn),
    .rd_addr  (rdAddr),
    .rd_data  (rdDataA),
    .rd_valid (rdValidA)
  );

  regfile_pipe #(.WIDTH(64), .DEPTH(32), .NRD(2), .ZERO_REG(0)) dutB (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wrEn),
    .wr_addr  (wrAddr),
    .wr_data  (wrData),
    .rd_en    (rdEn),
    .rd_addr  (rdAddr),
    .rd_data  (rdDataB),
    .rd_valid (rdValidB)
  );

  always #5 clk = ~clk;

  // Drive at the falling edge, then return 1ns after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wa,
                               input logic [63:0] wd, input logic [1:0] re,
                               input logic [4:0] ra0, input logic [4:0] ra1);
    @(negedge clk);
    reset  = rst;
    wrEn   = we;
    wrAddr = wa;
    wrData = wd;
    rdEn   = re;
    rdAddr = {ra1, ra0};
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    wrEn   = 1'b0;
    wrAddr = '0;
    wrData = '0;
    rdEn   = '0;
    rdAddr = '0;

    //            rst  we  wa  wd      re     ra0 ra1 valid  exp0   exp1
    vecs[0]  = '{1'b1, 1'b0, 5'd0,  64'h0,  2'b00, 5'd0,  5'd0, 2'b00, 64'h0,  64'h0};
    vecs[1]  = '{1'b0, 1'b0, 5'd0,  64'h0,  2'b11, 5'd0,  5'd5, 2'b11, 64'h0,  64'h0};
    vecs[2]  = '{1'b0, 1'b1, 5'd3,  DEAD,   2'b00, 5'd0,  5'd0, 2'b00, 64'h0,  64'h0};
    vecs[3]  = '{1'b0, 1'b0, 5'd0,  64'h0,  2'b01, 5'd3,  5'd0, 2'b01, DEAD,   64'h0};
    vecs[4]  = '{1'b0, 1'b1, 5'd7,  64'h55, 2'b10, 5'd0,  5'd7, 2'b10, DEAD,   64'h55};
    vecs[5]  = '{1'b0, 1'b1, 5'd31, ONES,   2'b11, 5'd31, 5'd31, 2'b11, 64'h0, 64'h0};
    vecs[6]  = '{1'b0, 1'b0, 5'd0,  64'h0,  2'b11, 5'd31, 5'd3, 2'b11, 64'h0,  DEAD};
    vecs[7]  = '{1'b0, 1'b0, 5'd0,  64'h0,  2'b00, 5'd0,  5'd0, 2'b00, 64'h0,  DEAD};
    vecs[8]  = '{1'b0, 1'b0, 5'd0,  64'h0,  2'b11, 5'd7,  5'd7, 2'b11, 64'h55, 64'h55};
    vecs[9]  = '{1'b0, 1'b1, 5'd7,  64'h77, 2'b01, 5'd7,  5'd7, 2'b01, 64'h77, 64'h55};
    vecs[10] = '{1'b0, 1'b1, 5'd9,  64'h99, 2'b00, 5'd0,  5'd0, 2'b00, 64'h77, 64'h55};
    vecs[11] = '{1'b1, 1'b1, 5'd9,  64'hAB, 2'b11, 5'd9,  5'd9, 2'b00, 64'h0,  64'h0};
    vecs[12] = '{1'b0, 1'b0, 5'd0,  64'h0,  2'b11, 5'd9,  5'd3, 2'b11, 64'h0,  64'h0};
    vecs[13] = '{1'b0, 1'b0, 5'd0,  64'h0,  2'b01, 5'd7,  5'd0, 2'b01, 64'h0,  64'h0};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
                    vecs[i].re, vecs[i].ra0, vecs[i].ra1);
      checkOutput($sformatf("vec%0d_valid", i), 64'(rdValidA), 64'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_data0", i), rdDataA[63:0], vecs[i].exp0);
      checkOutput($sformatf("vec%0d_data1", i), rdDataA[127:64], vecs[i].exp1);
    end

    // Register 31: zero on the XZR build, ordinary storage on the other.
    applyStimulus(1'b0, 1'b1, 5'd31, ONES, 2'b00, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 2'b11, 5'd31, 5'd31);
    checkOutput("xzr_valid",   64'(rdValidA), 64'h3);
    checkOutput("xzr_data0",   rdDataA[63:0],   64'h0);
    checkOutput("xzr_data1",   rdDataA[127:64], 64'h0);
    checkOutput("plain_valid", 64'(rdValidB), 64'h3);
    checkOutput("plain_data0", rdDataB[63:0],   ONES);
    checkOutput("plain_data1", rdDataB[127:64], ONES);

    // Fill every writable register, then sweep reads with idle gaps.
    applyStimulus(1'b1, 1'b0, 5'd0, 64'h0, 2'b00, 5'd0, 5'd0);
    for (int i = 0; i < 31; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(i), 64'(i) * 64'h0101, 2'b00, 5'd0, 5'd0);
    end
    for (int i = 0; i < 32; i++) begin
      automatic logic [63:0] e = (i == 31) ? 64'h0 : 64'(i) * 64'h0101;
      applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 2'b11, 5'(i), 5'(i));
      checkOutput($sformatf("sweep%0d_valid", i), 64'(rdValidA), 64'h3);
      checkOutput($sformatf("sweep%0d_data0", i), rdDataA[63:0], e);
      checkOutput($sformatf("sweep%0d_data1", i), rdDataA[127:64], e);
      applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 2'b00, 5'd0, 5'd0);
      checkOutput($sformatf("idle%0d_valid", i), 64'(rdValidA), 64'h0);
      checkOutput($sformatf("idle%0d_hold", i), rdDataA[63:0], e);
    end

    // Reset aimed at a pending read; the write to 9 must not survive either.
    applyStimulus(1'b0, 1'b1, 5'd9, 64'h99, 2'b00, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 64'h0, 2'b01, 5'd9, 5'd0);
    checkOutput("rst_valid", 64'(rdValidA), 64'h0);
    checkOutput("rst_data0", rdDataA[63:0], 64'h0);
    applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 2'b01, 5'd9, 5'd0);
    checkOutput("post_rst_valid", 64'(rdValidA), 64'h1);
    checkOutput("post_rst_data0", rdDataA[63:0], 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
